chess_turn_controller: RTL
==========================

Name: chess_turn_controller

Overview:
- Master side of the timer run/pause interface. Decides which player's countdown runs, driving each timer's start/pause flag from pushbuttons.
- Consumes each timer's zero indication and declares flag-fall. Tracks full-move count.
- Sits between board pushbuttons and two countdown timer instances (white, black).

Parameters:
- MAX_MOVES, 999, saturation value of the move counter.
- INC_EN, 0, 1 = emit an increment-credit pulse to the player who just completed a move.

Ports:
- OutClock  input  1  block clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high.
- StartBtn  input  1  raw pushbutton level: start game / clear after game over.
- PauseBtn  input  1  raw pushbutton level: pause/resume toggle.
- WhiteBtn  input  1  raw pushbutton level: white ends its move.
- BlackBtn  input  1  raw pushbutton level: black ends its move.
- ZeroWhite  input  1  synchronous level from white timer: time is 0:00.
- ZeroBlack  input  1  synchronous level from black timer: time is 0:00.
- FlagWhite  output  1  run flag to white timer.
- FlagBlack  output  1  run flag to black timer.
- IncWhite  output  1  one-cycle increment credit for white.
- IncBlack  output  1  one-cycle increment credit for black.
- Turn  output  1  0 = white to move, 1 = black to move.
- Paused  output  1  high in PAUSED.
- GameOver  output  1  high in GAME_OVER.
- Winner  output  2  00 none, 01 white, 10 black.
- MoveCount  output  10  completed full moves, saturating at MAX_MOVES.

Behaviour:
- Reset (async): state IDLE; all outputs 0; synchronizer and edge registers 0.
- Button path: each raw button passes through a 2-flop synchronizer, then a rising-edge detector, giving one pulse per press. Holding a button does not repeat.
- Button latency: raw input first sampled high at edge N; state and outputs update at edge N+2.
- Zero inputs are used directly with no synchronizer. Their effect is visible at the next edge.
- All outputs are registered. FlagWhite is high iff state = WHITE_RUN; FlagBlack is high iff state = BLACK_RUN.
- Priority within a cycle: zero > start > pause > move.
- IDLE:
  - Start pulse -> WHITE_RUN, Turn = 0.
  - All other inputs ignored.
- WHITE_RUN:
  - ZeroWhite -> GAME_OVER, Winner = 10.
  - Pause pulse -> PAUSED; Turn is held.
  - White pulse -> BLACK_RUN, Turn = 1; IncWhite pulses for 1 cycle if INC_EN = 1.
  - Black pulse, ZeroBlack and Start are ignored.
- BLACK_RUN (mirror of WHITE_RUN):
  - ZeroBlack -> GAME_OVER, Winner = 01.
  - Black pulse -> WHITE_RUN, Turn = 0, MoveCount increments (saturating at MAX_MOVES); IncBlack pulses if INC_EN = 1.
  - White pulse, ZeroWhite and Start are ignored.
- PAUSED:
  - Both flags are 0; Paused = 1.
  - Pause pulse -> WHITE_RUN if Turn = 0, else BLACK_RUN.
  - Move pulses, zeros and Start are ignored.
- GAME_OVER:
  - Flags are 0; GameOver = 1; Winner and MoveCount hold.
  - Start pulse -> IDLE, clearing Winner, MoveCount and Turn.
- Simultaneous both zeros: only the side to move is examined, so the side to move loses.
- Move pulse and pause pulse in the same cycle: pause wins and the move is discarded.
- Reset mid-game: immediate return to IDLE; the flags drop asynchronously.
- IncWhite and IncBlack are never high together, and never high outside the cycle of a move transition.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, WHITE_RUN, BLACK_RUN, PAUSED, GAME_OVER;
  - Winner codes: NONE = 00, WHITE = 01, BLACK = 10;
  - MoveCount width = 10.
- One sub-module: button_pulse_sync. It is a 2-flop synchronizer plus rising-edge detector with async reset, instantiated four times.
- The FSM and counter stay in the top level.

Test Plan:
- Reset, then StartBtn held high before edge 0 -> FlagWhite = 1 at edge 2, Turn = 0, FlagBlack = 0.
- From WHITE_RUN: WhiteBtn press, then BlackBtn press, with INC_EN = 1 -> Turn alternates, flags swap, MoveCount = 1 after black's move, IncWhite and IncBlack each pulse exactly 1 cycle.
- In BLACK_RUN: PauseBtn press -> both flags 0, Paused = 1. WhiteBtn and BlackBtn presses are ignored. Second PauseBtn press -> FlagBlack = 1 again.
- In WHITE_RUN: assert ZeroWhite and ZeroBlack together -> GameOver = 1, Winner = 10, flags 0. StartBtn press -> IDLE with Winner = 00 and MoveCount = 0.
- Run 1005 full moves -> MoveCount stops at 999.
- Hold WhiteBtn high for 50 cycles in WHITE_RUN -> exactly one turn change. Assert reset mid-game -> all outputs 0 with no clock edge needed.

Source files
------------

// File: rtl/chess_turn_controller_pkg.sv
// rtl/chess_turn_controller_pkg.sv - shared state, winner and counter definitions for the turn controller
package chess_turn_controller_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WHITE_RUN = 3'd1,
        BLACK_RUN = 3'd2,
        PAUSED    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_WHITE = 2'b01;
    localparam logic [1:0] WIN_BLACK = 2'b10;

    localparam int MOVE_W = 10;

endpackage

// File: rtl/chess_turn_controller_button_pulse_sync.sv
// rtl/chess_turn_controller_button_pulse_sync.sv - 2-flop synchronizer plus rising-edge detector for one pushbutton
module button_pulse_sync (
    input  logic OutClock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    // Two flops tame the asynchronous button level; the third keeps last cycle's value for edge detection.
    always_ff @(posedge OutClock or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= btn;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    // One pulse per press, no matter how long the button is held.
    assign pulse = sync & ~sync_d;

endmodule

// File: rtl/chess_turn_controller.sv
// rtl/chess_turn_controller.sv - turn/pause/flag-fall FSM driving the two countdown timers
module chess_turn_controller
    import chess_turn_controller_pkg::*;
#(
    parameter int MAX_MOVES = 999,
    parameter bit INC_EN    = 1'b0
) (
    input  logic              OutClock,
    input  logic              reset,
    input  logic              StartBtn,
    input  logic              PauseBtn,
    input  logic              WhiteBtn,
    input  logic              BlackBtn,
    input  logic              ZeroWhite,
    input  logic              ZeroBlack,
    output logic              FlagWhite,
    output logic              FlagBlack,
    output logic              IncWhite,
    output logic              IncBlack,
    output logic              Turn,
    output logic              Paused,
    output logic              GameOver,
    output logic [1:0]        Winner,
    output logic [MOVE_W-1:0] MoveCount
);

    localparam logic [MOVE_W-1:0] MOVE_MAX = MOVE_W'(MAX_MOVES);

    state_t state;
    logic   start_p;
    logic   pause_p;
    logic   white_p;
    logic   black_p;

    button_pulse_sync u_start (.OutClock(OutClock), .reset(reset), .btn(StartBtn), .pulse(start_p));
    button_pulse_sync u_pause (.OutClock(OutClock), .reset(reset), .btn(PauseBtn), .pulse(pause_p));
    button_pulse_sync u_white (.OutClock(OutClock), .reset(reset), .btn(WhiteBtn), .pulse(white_p));
    button_pulse_sync u_black (.OutClock(OutClock), .reset(reset), .btn(BlackBtn), .pulse(black_p));

    // Game FSM with every output registered; within a state, zero beats start beats pause beats move.
    always_ff @(posedge OutClock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            FlagWhite <= 1'b0;
            FlagBlack <= 1'b0;
            IncWhite  <= 1'b0;
            IncBlack  <= 1'b0;
            Turn      <= 1'b0;
            Paused    <= 1'b0;
            GameOver  <= 1'b0;
            Winner    <= WIN_NONE;
            MoveCount <= '0;
        end else begin
            IncWhite <= 1'b0;
            IncBlack <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_p) begin
                        state     <= WHITE_RUN;
                        Turn      <= 1'b0;
                        FlagWhite <= 1'b1;
                    end
                end
                WHITE_RUN: begin
                    if (ZeroWhite) begin
                        state     <= GAME_OVER;
                        FlagWhite <= 1'b0;
                        GameOver  <= 1'b1;
                        Winner    <= WIN_BLACK;
                    end else if (pause_p) begin
                        state     <= PAUSED;
                        FlagWhite <= 1'b0;
                        Paused    <= 1'b1;
                    end else if (white_p) begin
                        state     <= BLACK_RUN;
                        Turn      <= 1'b1;
                        FlagWhite <= 1'b0;
                        FlagBlack <= 1'b1;
                        IncWhite  <= INC_EN;
                    end
                end
                BLACK_RUN: begin
                    if (ZeroBlack) begin
                        state     <= GAME_OVER;
                        FlagBlack <= 1'b0;
                        GameOver  <= 1'b1;
                        Winner    <= WIN_WHITE;
                    end else if (pause_p) begin
                        state     <= PAUSED;
                        FlagBlack <= 1'b0;
                        Paused    <= 1'b1;
                    end else if (black_p) begin
                        state     <= WHITE_RUN;
                        Turn      <= 1'b0;
                        FlagBlack <= 1'b0;
                        FlagWhite <= 1'b1;
                        IncBlack  <= INC_EN;
                        if (MoveCount < MOVE_MAX) begin
                            MoveCount <= MoveCount + 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (pause_p) begin
                        Paused <= 1'b0;
                        if (Turn) begin
                            state     <= BLACK_RUN;
                            FlagBlack <= 1'b1;
                        end else begin
                            state     <= WHITE_RUN;
                            FlagWhite <= 1'b1;
                        end
                    end
                end
                GAME_OVER: begin
                    if (start_p) begin
                        state     <= IDLE;
                        GameOver  <= 1'b0;
                        Winner    <= WIN_NONE;
                        MoveCount <= '0;
                        Turn      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    FlagWhite <= 1'b0;
                    FlagBlack <= 1'b0;
                    Paused    <= 1'b0;
                    GameOver  <= 1'b0;
                end
            endcase
        end
    end

endmodule
